// File: rtl/sdr_cmd_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : sdr_cmd_arb_if
// Description : Bundle of the handshake, command-bus and SDRAM pin signals
//               shared by the command arbiter and the controller around it.
//               The slave modport is the arbiter's view and the master
//               modport is the controller's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdr_cmd_arb_if #(
    parameter int BA_W = 2,
    parameter int AD_W = 13
);
    // Init/refresh handshake and burst status
    logic            Sdr_init_done;
    logic            Sdr_ref_req;
    logic            Sdr_ref_ack;
    logic            Sdr_rw_vld;

    // Init/refresh command bus
    logic            Sdr_init_ref_vld;
    logic            Sdr_init_ref_ras;
    logic            Sdr_init_ref_cas;
    logic            Sdr_init_ref_we;
    logic [BA_W-1:0] Sdr_init_ref_ba;
    logic [AD_W-1:0] Sdr_init_ref_addr;

    // Read/write burst handshake
    logic            Rw_req;
    logic            Rw_ack;
    logic            Rw_done;

    // Read/write command bus
    logic            Rw_cmd_vld;
    logic            Rw_ras;
    logic            Rw_cas;
    logic            Rw_we;
    logic [BA_W-1:0] Rw_ba;
    logic [AD_W-1:0] Rw_addr;

    // Registered SDRAM command pins
    logic            SDRAM_RAS_N;
    logic            SDRAM_CAS_N;
    logic            SDRAM_WE_N;
    logic [BA_W-1:0] SDRAM_BA;
    logic [AD_W-1:0] SDRAM_ADDR;

    modport slave (
        input  Sdr_init_done, Sdr_ref_req,
        output Sdr_ref_ack, Sdr_rw_vld,
        input  Sdr_init_ref_vld, Sdr_init_ref_ras, Sdr_init_ref_cas,
        input  Sdr_init_ref_we, Sdr_init_ref_ba, Sdr_init_ref_addr,
        input  Rw_req, Rw_done,
        output Rw_ack,
        input  Rw_cmd_vld, Rw_ras, Rw_cas, Rw_we, Rw_ba, Rw_addr,
        output SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N, SDRAM_BA, SDRAM_ADDR
    );

    modport master (
        output Sdr_init_done, Sdr_ref_req,
        input  Sdr_ref_ack, Sdr_rw_vld,
        output Sdr_init_ref_vld, Sdr_init_ref_ras, Sdr_init_ref_cas,
        output Sdr_init_ref_we, Sdr_init_ref_ba, Sdr_init_ref_addr,
        output Rw_req, Rw_done,
        input  Rw_ack,
        output Rw_cmd_vld, Rw_ras, Rw_cas, Rw_we, Rw_ba, Rw_addr,
        input  SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N, SDRAM_BA, SDRAM_ADDR
    );
endinterface
`default_nettype wire

// File: rtl/sdr_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module      : sdr_cmd_arb
// Description : SDRAM command arbiter and pin driver. Grants refresh only
//               between bursts, holds off new bursts for REF_HOLD cycles
//               after each refresh grant, and registers the selected command
//               bus onto the SDRAM pins (NOP when no bus is valid).
//               Optional feature macro: SDR_REF_TIMEOUT_EN adds a refresh
//               wait counter, the sticky Ref_overdue output and burst
//               suppression while a refresh is overdue.
// Revision    : 1.0 - initial release
// ============================================================================
module sdr_cmd_arb #(
    parameter int BA_W         = 2,
    parameter int AD_W         = 13,
    parameter int REF_HOLD     = 20,
    parameter int REF_MAX_WAIT = 1024
) (
    input  wire logic    Sdr_clk,
    input  wire logic    Rst,
`ifdef SDR_REF_TIMEOUT_EN
    output logic         Ref_overdue,
`endif
    sdr_cmd_arb_if.slave bus
);

    localparam int                     c_HOLD_W    = (REF_HOLD > 1) ? $clog2(REF_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0]    c_HOLD_LOAD = c_HOLD_W'(REF_HOLD - 1);

    // Elaboration-time guard against unusable parameter values
    if (REF_HOLD < 2 || REF_MAX_WAIT < 1) begin : g_param_check
        $error("sdr_cmd_arb: REF_HOLD must be >= 2 and REF_MAX_WAIT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RW   = 2'd1,
        S_REF  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ref_pend;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_ref_ack;
    logic                  r_rw_ack;

    logic                  w_eval;
    logic                  w_ref_grant;
    logic                  w_rw_grant;
    logic                  w_rw_block;

    logic                  r_ras_n;
    logic                  r_cas_n;
    logic                  r_we_n;
    logic [BA_W-1:0]       r_ba;
    logic [AD_W-1:0]       r_addr;

    // Grant decisions and next state. The last REF cycle (counter at 0)
    // already arbitrates like IDLE so that REF occupies exactly REF_HOLD
    // cycles and a waiting burst is acked right after it.
    always_comb begin
        w_state_nxt = r_state;
        w_eval      = (r_state == S_IDLE) ||
                      ((r_state == S_REF) && (r_hold_cnt == '0));
        w_ref_grant = w_eval && (r_ref_pend || bus.Sdr_ref_req);
        w_rw_grant  = w_eval && !w_ref_grant && bus.Rw_req &&
                      bus.Sdr_init_done && !w_rw_block;
        case (r_state)
            S_IDLE, S_REF: begin
                if (w_ref_grant) begin
                    w_state_nxt = S_REF;
                end else if (w_rw_grant) begin
                    w_state_nxt = S_RW;
                end else if (w_eval) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RW: begin
                if (bus.Rw_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, registered acks, pending refresh and REF hold counter
    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_ref_pend <= 1'b0;
            r_hold_cnt <= '0;
            r_ref_ack  <= 1'b0;
            r_rw_ack   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ref_ack <= w_ref_grant;
            r_rw_ack  <= w_rw_grant;
            if (w_ref_grant) begin
                r_ref_pend <= 1'b0;
            end else if (bus.Sdr_ref_req) begin
                r_ref_pend <= 1'b1;
            end
            if (w_ref_grant) begin
                r_hold_cnt <= c_HOLD_LOAD;
            end else if ((r_state == S_REF) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

    // Command pin register: init/refresh bus first, then read/write bus,
    // otherwise NOP with bank/address held.
    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            r_ras_n <= 1'b1;
            r_cas_n <= 1'b1;
            r_we_n  <= 1'b1;
            r_ba    <= '0;
            r_addr  <= '0;
        end else if (bus.Sdr_init_ref_vld) begin
            r_ras_n <= bus.Sdr_init_ref_ras;
            r_cas_n <= bus.Sdr_init_ref_cas;
            r_we_n  <= bus.Sdr_init_ref_we;
            r_ba    <= bus.Sdr_init_ref_ba;
            r_addr  <= bus.Sdr_init_ref_addr;
        end else if (bus.Rw_cmd_vld) begin
            r_ras_n <= bus.Rw_ras;
            r_cas_n <= bus.Rw_cas;
            r_we_n  <= bus.Rw_we;
            r_ba    <= bus.Rw_ba;
            r_addr  <= bus.Rw_addr;
        end else begin
            r_ras_n <= 1'b1;
            r_cas_n <= 1'b1;
            r_we_n  <= 1'b1;
        end
    end

    assign bus.Sdr_ref_ack = r_ref_ack;
    assign bus.Rw_ack      = r_rw_ack;
    assign bus.Sdr_rw_vld  = (r_state == S_RW);
    assign bus.SDRAM_RAS_N = r_ras_n;
    assign bus.SDRAM_CAS_N = r_cas_n;
    assign bus.SDRAM_WE_N  = r_we_n;
    assign bus.SDRAM_BA    = r_ba;
    assign bus.SDRAM_ADDR  = r_addr;

`ifdef SDR_REF_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_nxt;
    logic        r_overdue;

    // Wait counter counts every cycle a refresh is outstanding, including
    // the request cycle itself, and saturates rather than wrapping.
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (w_ref_grant) begin
            w_wait_nxt = '0;
        end else if ((r_ref_pend || bus.Sdr_ref_req) && (r_wait_cnt != 16'hFFFF)) begin
            w_wait_nxt = r_wait_cnt + 16'd1;
        end
    end

    // Wait counter and sticky overdue flag
    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            r_wait_cnt <= '0;
            r_overdue  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (32'(w_wait_nxt) >= 32'(REF_MAX_WAIT)) begin
                r_overdue <= 1'b1;
            end
        end
    end

    assign w_rw_block  = (32'(r_wait_cnt) >= 32'(REF_MAX_WAIT));
    assign Ref_overdue = r_overdue;
`else
    assign w_rw_block  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdr_cmd_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdr_cmd_arb
// Description : Self-checking bench for sdr_cmd_arb. Ack timing is checked by
//               a scoreboard of expected ack cycles; pins by a small model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdr_cmd_arb;

    localparam int BA_W         = 2;
    localparam int AD_W         = 13;
    localparam int REF_HOLD     = 20;
    localparam int REF_MAX_WAIT = 16;

    logic Sdr_clk = 1'b0;
    logic Rst     = 1'b1;
`ifdef SDR_REF_TIMEOUT_EN
    logic Ref_overdue;
`endif

    sdr_cmd_arb_if #(.BA_W(BA_W), .AD_W(AD_W)) bus ();

    sdr_cmd_arb #(
        .BA_W(BA_W), .AD_W(AD_W), .REF_HOLD(REF_HOLD), .REF_MAX_WAIT(REF_MAX_WAIT)
    ) dut (
        .Sdr_clk    (Sdr_clk),
        .Rst        (Rst),
`ifdef SDR_REF_TIMEOUT_EN
        .Ref_overdue(Ref_overdue),
`endif
        .bus        (bus.slave)
    );

    always #5 Sdr_clk = ~Sdr_clk;

    int cyc = 0;
    always @(posedge Sdr_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Scoreboards of expected ack cycles
    int exp_ref_q[$];
    int exp_rw_q[$];
    int ref_seen = 0;
    int mon_e;

    typedef struct packed {
        logic            ras, cas, we;
        logic [BA_W-1:0] ba;
        logic [AD_W-1:0] addr;
    } pins_t;
    pins_t pin_q[$];

    // Ack monitor: every ack pulse must match the next expected cycle
    always @(negedge Sdr_clk) begin
        if (bus.Sdr_ref_ack === 1'b1) begin
            ref_seen++;
            total++;
            if (exp_ref_q.size() == 0) begin
                bad++;
                $display("FAIL ref_ack_unexpected: ack at cycle %0d, none expected", cyc);
            end else begin
                mon_e = exp_ref_q.pop_front();
                if (cyc !== mon_e) begin
                    bad++;
                    $display("FAIL ref_ack_cycle: got cycle %0d, expected %0d", cyc, mon_e);
                end
            end
        end
        if (bus.Rw_ack === 1'b1) begin
            total++;
            if (exp_rw_q.size() == 0) begin
                bad++;
                $display("FAIL rw_ack_unexpected: ack at cycle %0d, none expected", cyc);
            end else begin
                mon_e = exp_rw_q.pop_front();
                if (cyc !== mon_e) begin
                    bad++;
                    $display("FAIL rw_ack_cycle: got cycle %0d, expected %0d", cyc, mon_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge Sdr_clk);
        #1;
    endtask

    task automatic wait_rw_ack(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (bus.Rw_ack === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic pulse_done();
        bus.Rw_done = 1'b1;
        step();
        bus.Rw_done = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) step();
        total++;
        if ({bus.Sdr_ref_ack, bus.Rw_ack, bus.Sdr_rw_vld} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: ref_ack/rw_ack/rw_vld=%b expected 000",
                     {bus.Sdr_ref_ack, bus.Rw_ack, bus.Sdr_rw_vld});
        end
        total++;
        if ({bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N, bus.SDRAM_BA, bus.SDRAM_ADDR}
            !== {3'b111, {BA_W{1'b0}}, {AD_W{1'b0}}}) begin
            bad++;
            $display("FAIL reset_pins: got %b/%0h/%0h expected 111/0/0",
                     {bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N}, bus.SDRAM_BA, bus.SDRAM_ADDR);
        end
`ifdef SDR_REF_TIMEOUT_EN
        total++;
        if (Ref_overdue !== 1'b0) begin
            bad++;
            $display("FAIL reset_overdue: got %b expected 0", Ref_overdue);
        end
`endif
        Rst = 1'b0;
        step();
    endtask

    task automatic test_idle_refresh();
        int t0;
        bit seen;
        t0 = cyc;
        bus.Sdr_ref_req = 1'b1;
        exp_ref_q.push_back(t0 + 1);
        step();
        bus.Sdr_ref_req = 1'b0;
        step();
        bus.Rw_req = 1'b1;
        exp_rw_q.push_back(t0 + REF_HOLD + 1);
        wait_rw_ack(REF_HOLD + 10, seen);
        bus.Rw_req = 1'b0;
        total++;
        if (!seen || cyc != t0 + REF_HOLD + 1) begin
            bad++;
            $display("FAIL idle_ref_rw_ack: seen=%0d at cycle %0d expected cycle %0d",
                     seen, cyc, t0 + REF_HOLD + 1);
        end
        total++;
        if (bus.Sdr_rw_vld !== 1'b1) begin
            bad++;
            $display("FAIL idle_ref_rw_vld: got %b expected 1", bus.Sdr_rw_vld);
        end
        repeat (3) step();
        pulse_done();
        total++;
        if (bus.Sdr_rw_vld !== 1'b0) begin
            bad++;
            $display("FAIL idle_ref_vld_fall: got %b expected 0", bus.Sdr_rw_vld);
        end
        step();
    endtask

    task automatic test_ref_during_burst();
        int t0;
        bit seen;
        t0 = cyc;
        bus.Rw_req = 1'b1;
        exp_rw_q.push_back(t0 + 1);
        wait_rw_ack(5, seen);
        bus.Rw_req = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL burst_rw_ack: no ack within 5 cycles, expected at %0d", t0 + 1);
        end
        step();
        step();
        bus.Sdr_ref_req = 1'b1;
        step();
        bus.Sdr_ref_req = 1'b0;
        repeat (5) step();
        total++;
        if ({bus.Sdr_rw_vld, bus.Sdr_ref_ack} !== 2'b10) begin
            bad++;
            $display("FAIL burst_not_preempted: rw_vld/ref_ack=%b expected 10",
                     {bus.Sdr_rw_vld, bus.Sdr_ref_ack});
        end
        exp_ref_q.push_back(cyc + 2);
        pulse_done();
        total++;
        if (bus.Sdr_rw_vld !== 1'b0) begin
            bad++;
            $display("FAIL burst_vld_fall: got %b expected 0", bus.Sdr_rw_vld);
        end
        step();
        total++;
        if (bus.Sdr_ref_ack !== 1'b1) begin
            bad++;
            $display("FAIL burst_ref_ack_after_done: got %b expected 1", bus.Sdr_ref_ack);
        end
        repeat (REF_HOLD + 2) step();
    endtask

    task automatic test_simultaneous();
        int t0;
        int viol;
        t0 = cyc;
        viol = 0;
        bus.Sdr_ref_req = 1'b1;
        bus.Rw_req      = 1'b1;
        exp_ref_q.push_back(t0 + 1);
        exp_rw_q.push_back(t0 + REF_HOLD + 1);
        step();
        bus.Sdr_ref_req = 1'b0;
        for (int i = 0; i < REF_HOLD; i++) begin
            if (bus.Sdr_rw_vld !== 1'b0 || bus.Rw_ack !== 1'b0) viol++;
            step();
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL simul_ref_quiet: %0d cycles with rw activity during REF, expected 0", viol);
        end
        total++;
        if ({bus.Rw_ack, bus.Sdr_rw_vld} !== 2'b11) begin
            bad++;
            $display("FAIL simul_rw_after_ref: rw_ack/rw_vld=%b expected 11",
                     {bus.Rw_ack, bus.Sdr_rw_vld});
        end
        bus.Rw_req = 1'b0;
        step();
        pulse_done();
        step();
    endtask

    task automatic test_init_done();
        int viol;
        bit seen;
        viol = 0;
        bus.Sdr_init_done = 1'b0;
        bus.Rw_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.Rw_ack !== 1'b0 || bus.Sdr_rw_vld !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL init_low_blocks_rw: %0d cycles with rw grant, expected 0", viol);
        end
        bus.Rw_req = 1'b0;
        bus.Sdr_ref_req = 1'b1;
        exp_ref_q.push_back(cyc + 1);
        step();
        bus.Sdr_ref_req = 1'b0;
        total++;
        if (bus.Sdr_ref_ack !== 1'b1) begin
            bad++;
            $display("FAIL init_low_ref_ack: got %b expected 1", bus.Sdr_ref_ack);
        end
        repeat (REF_HOLD + 2) step();
        bus.Sdr_init_done = 1'b1;
        bus.Rw_req = 1'b1;
        exp_rw_q.push_back(cyc + 1);
        wait_rw_ack(5, seen);
        bus.Rw_req = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL init_high_rw_ack: no ack within 5 cycles, expected 1");
        end
        step();
        pulse_done();
        step();
    endtask

    task automatic test_pin_mux();
        pins_t exp_p;
        pins_t got_p;
        logic [BA_W-1:0] m_ba;
        logic [AD_W-1:0] m_addr;
        // Both valid: init/refresh bus wins
        bus.Sdr_init_ref_vld = 1'b1;
        {bus.Sdr_init_ref_ras, bus.Sdr_init_ref_cas, bus.Sdr_init_ref_we} = 3'b001;
        bus.Sdr_init_ref_ba   = 2'd2;
        bus.Sdr_init_ref_addr = 13'h0123;
        bus.Rw_cmd_vld = 1'b1;
        {bus.Rw_ras, bus.Rw_cas, bus.Rw_we} = 3'b100;
        bus.Rw_ba   = 2'd1;
        bus.Rw_addr = 13'h0456;
        step();
        total++;
        if ({bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N, bus.SDRAM_BA, bus.SDRAM_ADDR}
            !== {3'b001, 2'd2, 13'h0123}) begin
            bad++;
            $display("FAIL pin_init_priority: got %b/%0h/%0h expected 001/2/123",
                     {bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N}, bus.SDRAM_BA, bus.SDRAM_ADDR);
        end
        bus.Sdr_init_ref_vld = 1'b0;
        step();
        total++;
        if ({bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N, bus.SDRAM_BA, bus.SDRAM_ADDR}
            !== {3'b100, 2'd1, 13'h0456}) begin
            bad++;
            $display("FAIL pin_rw_select: got %b/%0h/%0h expected 100/1/456",
                     {bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N}, bus.SDRAM_BA, bus.SDRAM_ADDR);
        end
        bus.Rw_cmd_vld = 1'b0;
        step();
        total++;
        if ({bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N, bus.SDRAM_BA, bus.SDRAM_ADDR}
            !== {3'b111, 2'd1, 13'h0456}) begin
            bad++;
            $display("FAIL pin_nop_hold: got %b/%0h/%0h expected 111/1/456",
                     {bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N}, bus.SDRAM_BA, bus.SDRAM_ADDR);
        end
        // Random traffic against a small pin model
        m_ba   = 2'd1;
        m_addr = 13'h0456;
        for (int i = 0; i < 24; i++) begin
            bus.Sdr_init_ref_vld  = ($urandom_range(0, 2) == 0);
            bus.Rw_cmd_vld        = ($urandom_range(0, 1) == 0);
            {bus.Sdr_init_ref_ras, bus.Sdr_init_ref_cas, bus.Sdr_init_ref_we} = 3'($urandom);
            {bus.Rw_ras, bus.Rw_cas, bus.Rw_we} = 3'($urandom);
            bus.Sdr_init_ref_ba   = BA_W'($urandom);
            bus.Sdr_init_ref_addr = AD_W'($urandom);
            bus.Rw_ba             = BA_W'($urandom);
            bus.Rw_addr           = AD_W'($urandom);
            if (bus.Sdr_init_ref_vld) begin
                m_ba   = bus.Sdr_init_ref_ba;
                m_addr = bus.Sdr_init_ref_addr;
                exp_p  = {bus.Sdr_init_ref_ras, bus.Sdr_init_ref_cas, bus.Sdr_init_ref_we, m_ba, m_addr};
            end else if (bus.Rw_cmd_vld) begin
                m_ba   = bus.Rw_ba;
                m_addr = bus.Rw_addr;
                exp_p  = {bus.Rw_ras, bus.Rw_cas, bus.Rw_we, m_ba, m_addr};
            end else begin
                exp_p  = {3'b111, m_ba, m_addr};
            end
            pin_q.push_back(exp_p);
            step();
            exp_p = pin_q.pop_front();
            got_p = {bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N, bus.SDRAM_BA, bus.SDRAM_ADDR};
            total++;
            if (got_p !== exp_p) begin
                bad++;
                $display("FAIL pin_random[%0d]: got %h expected %h", i, got_p, exp_p);
            end
        end
        bus.Sdr_init_ref_vld = 1'b0;
        bus.Rw_cmd_vld       = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_rw();
        bit seen;
        int refs_before;
        bus.Rw_req = 1'b1;
        exp_rw_q.push_back(cyc + 1);
        wait_rw_ack(5, seen);
        bus.Rw_req = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_mid_rw_ack: no ack within 5 cycles, expected 1");
        end
        bus.Rw_cmd_vld = 1'b1;
        {bus.Rw_ras, bus.Rw_cas, bus.Rw_we} = 3'b010;
        bus.Rw_ba   = 2'd3;
        bus.Rw_addr = 13'h00AA;
        step();
        bus.Sdr_ref_req = 1'b1;
        step();
        bus.Sdr_ref_req = 1'b0;
        total++;
        if ({bus.Sdr_rw_vld, bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N} !== 4'b1010) begin
            bad++;
            $display("FAIL rst_mid_rw_pre: rw_vld/pins=%b expected 1010",
                     {bus.Sdr_rw_vld, bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N});
        end
        refs_before = ref_seen;
        Rst = 1'b1;
        step();
        total++;
        if ({bus.Sdr_rw_vld, bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N, bus.SDRAM_BA, bus.SDRAM_ADDR}
            !== {4'b0111, {BA_W{1'b0}}, {AD_W{1'b0}}}) begin
            bad++;
            $display("FAIL rst_mid_rw_state: rw_vld/pins=%b ba=%0h addr=%0h expected 0111/0/0",
                     {bus.Sdr_rw_vld, bus.SDRAM_RAS_N, bus.SDRAM_CAS_N, bus.SDRAM_WE_N},
                     bus.SDRAM_BA, bus.SDRAM_ADDR);
        end
        Rst = 1'b0;
        bus.Rw_cmd_vld = 1'b0;
        repeat (30) step();
        total++;
        if (ref_seen != refs_before) begin
            bad++;
            $display("FAIL rst_discards_ref: %0d ref acks after reset, expected 0", ref_seen - refs_before);
        end
    endtask

`ifdef SDR_REF_TIMEOUT_EN
    task automatic test_ref_timeout();
        int q;
        bit seen;
        bus.Rw_req = 1'b1;
        exp_rw_q.push_back(cyc + 1);
        wait_rw_ack(5, seen);
        bus.Rw_req = 1'b0;
        step();
        q = cyc;
        bus.Sdr_ref_req = 1'b1;
        step();
        bus.Sdr_ref_req = 1'b0;
        while (cyc < q + REF_MAX_WAIT - 1) step();
        total++;
        if (Ref_overdue !== 1'b0) begin
            bad++;
            $display("FAIL overdue_early: got %b at cycle %0d expected 0", Ref_overdue, cyc);
        end
        step();
        total++;
        if (Ref_overdue !== 1'b1) begin
            bad++;
            $display("FAIL overdue_rise: got %b at cycle %0d expected 1", Ref_overdue, cyc);
        end
        while (cyc < q + 30) step();
        exp_ref_q.push_back(cyc + 2);
        pulse_done();
        step();
        step();
        total++;
        if (Ref_overdue !== 1'b1) begin
            bad++;
            $display("FAIL overdue_sticky: got %b after ack expected 1", Ref_overdue);
        end
        repeat (REF_HOLD + 2) step();
    endtask
`endif

    initial begin
        bus.Sdr_init_done     = 1'b1;
        bus.Sdr_ref_req       = 1'b0;
        bus.Sdr_init_ref_vld  = 1'b0;
        bus.Sdr_init_ref_ras  = 1'b1;
        bus.Sdr_init_ref_cas  = 1'b1;
        bus.Sdr_init_ref_we   = 1'b1;
        bus.Sdr_init_ref_ba   = '0;
        bus.Sdr_init_ref_addr = '0;
        bus.Rw_req            = 1'b0;
        bus.Rw_done           = 1'b0;
        bus.Rw_cmd_vld        = 1'b0;
        bus.Rw_ras            = 1'b1;
        bus.Rw_cas            = 1'b1;
        bus.Rw_we             = 1'b1;
        bus.Rw_ba             = '0;
        bus.Rw_addr           = '0;

        test_reset();
        test_idle_refresh();
        test_ref_during_burst();
        test_simultaneous();
        test_init_done();
        test_pin_mux();
        test_reset_mid_rw();
`ifdef SDR_REF_TIMEOUT_EN
        test_ref_timeout();
`endif
        repeat (3) step();
        total++;
        if (exp_ref_q.size() != 0 || exp_rw_q.size() != 0) begin
            bad++;
            $display("FAIL missing_acks: %0d ref and %0d rw acks outstanding, expected 0",
                     exp_ref_q.size(), exp_rw_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdr_cmd_arb.md
# sdr_cmd_arb

Command arbiter and SDRAM pin driver on the controller side of the init/refresh handshake. It accepts refresh requests on `Sdr_ref_req` and returns `Sdr_ref_ack` only when no read/write burst is active. It reports burst activity on `Sdr_rw_vld`. It registers either the init/refresh command bus or the read/write command bus onto the SDRAM command pins, and inserts NOP when neither is valid.

## Interface
Parameters:
- `BA_W`, 2, bank address width.
- `AD_W`, 13, address width (row width + 1).
- `REF_HOLD`, 20, cycles the arbiter blocks new bursts after issuing `Sdr_ref_ack`.
- `REF_MAX_WAIT`, 1024, overdue threshold in cycles (used only with `SDR_REF_TIMEOUT_EN`).

Ports:
- `Sdr_clk` in 1: clock.
- `Rst` in 1: reset, synchronous, active-high. Clock is `Sdr_clk`.
- `Sdr_init_done` in 1: initialisation complete; bursts are refused while low.
- `Sdr_ref_req` in 1: refresh request pulse.
- `Sdr_ref_ack` out 1: refresh grant, one-cycle pulse.
- `Sdr_rw_vld` out 1: a read/write burst is in progress.
- `Sdr_init_ref_vld`, `Sdr_init_ref_ras`, `Sdr_init_ref_cas`, `Sdr_init_ref_we` in 1 each: init/refresh command bus.
- `Sdr_init_ref_ba` in `BA_W`, `Sdr_init_ref_addr` in `AD_W`: init/refresh bank and address.
- `Rw_req` in 1: burst request, held high until `Rw_ack`.
- `Rw_ack` out 1: burst accepted, one-cycle pulse.
- `Rw_done` in 1: last command of the burst issued, one-cycle pulse.
- `Rw_cmd_vld`, `Rw_ras`, `Rw_cas`, `Rw_we` in 1 each; `Rw_ba` in `BA_W`; `Rw_addr` in `AD_W`: read/write command bus.
- `SDRAM_RAS_N`, `SDRAM_CAS_N`, `SDRAM_WE_N` out 1 each; `SDRAM_BA` out `BA_W`; `SDRAM_ADDR` out `AD_W`: registered pins.
- `Ref_overdue` out 1: sticky overdue flag (present only with `SDR_REF_TIMEOUT_EN`).

## Operation
- `ref_pend` sets on `Sdr_ref_req`. It clears on the cycle `Sdr_ref_ack` is issued. A new request arriving while `ref_pend` is already set merges into the pending one.
- States:
  - IDLE:
    - If `ref_pend` is set, issue `Sdr_ref_ack` and go to REF.
    - Else if `Rw_req` is high and `Sdr_init_done` is high, issue `Rw_ack` and go to RW.
  - RW: `Sdr_rw_vld` is high. On `Rw_done`, go to IDLE.
  - REF: counter loads `REF_HOLD-1` and counts down to 0, then go to IDLE. `Rw_ack` is never issued in REF.
- Priority in IDLE: refresh wins over burst. A burst in progress is never pre-empted.
- `Sdr_rw_vld` is low in IDLE and REF. This guarantees that `Sdr_ref_ack` is only issued while `Sdr_rw_vld` = 0.
- Pin mux, evaluated each cycle and registered:
  - If `Sdr_init_ref_vld` is high, select the init/refresh bus.
  - Else if `Rw_cmd_vld` is high, select the read/write bus.
  - Else drive NOP: RAS/CAS/WE = 1, BA/ADDR hold their last value.
- Pins carry active-low polarity and are driven straight from the selected bus's ras/cas/we, with no inversion.
- `Sdr_init_done` falling in RW: the current burst still completes. In IDLE, no new `Rw_ack` is issued until `Sdr_init_done` returns high. Refresh acks are unaffected by `Sdr_init_done`.

## Timing
- Reset values:
  - `Sdr_ref_ack` = 0, `Rw_ack` = 0, `Sdr_rw_vld` = 0, `Ref_overdue` = 0.
  - RAS/CAS/WE = 1; `SDRAM_BA` = 0, `SDRAM_ADDR` = 0.
  - State = IDLE, `ref_pend` = 0.
- `Sdr_ref_req` at cycle N with the arbiter in IDLE: `Sdr_ref_ack` at N+1.
- `Sdr_ref_req` arriving during RW: `Sdr_ref_ack` the cycle after the state returns to IDLE, i.e. `Rw_done` + 2.
- `Rw_ack` is issued one cycle after `Rw_req` is seen in IDLE. `Sdr_rw_vld` rises in the same cycle as `Rw_ack` and falls the cycle after `Rw_done`.
- `Sdr_ref_req` and `Rw_req` high in the same IDLE cycle: the ack goes to refresh, and `Rw_ack` is issued `REF_HOLD`+1 cycles later.
- Pin latency is one cycle from the command bus to the pins.
- `Rst` asserted mid-burst or mid-REF: the next cycle returns to reset values, and pending requests are discarded.

## Configuration
- Macro: `SDR_REF_TIMEOUT_EN`.
- Defined:
  - A 16-bit wait counter runs while `ref_pend` = 1 and clears on `Sdr_ref_ack`.
  - When the counter reaches `REF_MAX_WAIT`, `Ref_overdue` sets and stays set until `Rst`.
  - While the counter is at or above `REF_MAX_WAIT`, `Rw_ack` is suppressed even if the state is IDLE.
- Undefined: no counter, and the `Ref_overdue` port is absent.

## Test plan
- Idle refresh: reset, `Sdr_init_done` = 1, pulse `Sdr_ref_req` at cycle 10 → `Sdr_ref_ack` at 11. Then `Rw_req` at 12 → `Rw_ack` at 31, not earlier.
- Refresh during burst: `Rw_ack` at 5, `Sdr_ref_req` at 8, `Rw_done` at 40 → `Sdr_rw_vld` falls at 41 and `Sdr_ref_ack` pulses at 42.
- Simultaneous requests: `Sdr_ref_req` and `Rw_req` in the same IDLE cycle → refresh acked first, and `Sdr_rw_vld` = 0 throughout REF.
- Pin mux: `Sdr_init_ref_vld` = 1 with ras/cas/we = 0/0/1 and `Rw_cmd_vld` = 1 at the same time → pins read 0/0/1 next cycle. With both valids low → pins read 1/1/1.
- Reset mid-RW: `Rst` asserted during RW → next cycle `Sdr_rw_vld` = 0, pins = NOP, and a `Sdr_ref_req` that was pending is not acked.
- With `SDR_REF_TIMEOUT_EN`, `REF_MAX_WAIT` = 16, and a burst held for 30 cycles after `Sdr_ref_req` → `Ref_overdue` rises 16 cycles after the request and stays high after the ack.
